// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 4-digit seven-segment scan sequencer with dead-time blanking, blink and frame-synchronous updates
// Optional macro SSD_DP_EN adds the per-digit decimal-point input dp_in.
module ssd_scan_ctrl #(
  parameter int SCAN_DIV     = 262144,
  parameter int BLANK_CYC    = 1024,
  parameter int BLINK_FRAMES = 48
) (
  input  logic        board_clk,
  input  logic        reset_n,
  input  logic [15:0] digits_in,
  input  logic        load,
`ifdef SSD_DP_EN
  input  logic [3:0]  dp_in,
`endif
  input  logic [3:0]  dig_en,
  input  logic [3:0]  blink_en,
  output logic        load_pending,
  output logic        frame_done,
  output logic [3:0]  An,
  output logic [6:0]  Cathodes,
  output logic        Dp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK   = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [15:0]     active, shadow;
  logic            slot_wrap, frame_wrap, lit;
  logic [3:0]      nibble;
  logic [3:0]      an_nxt;
  logic [6:0]      cath_nxt;
  logic            dp_nxt;
`ifdef SSD_DP_EN
  logic [3:0]      active_dp, shadow_dp;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0001100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    slot_wrap  = (cnt == CNT_LAST);
    frame_wrap = slot_wrap && (idx == 2'd3);
    cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
    state_nxt  = (cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    nibble     = active[{idx, 2'b00} +: 4];
    // A digit is dark when disabled or when its blink is in the off half-period.
    lit        = (state == ST_SHOW) && dig_en[idx] && !(blink_phase && blink_en[idx]);
    an_nxt     = lit ? ~(4'b0001 << idx) : 4'b1111;
    cath_nxt   = lit ? seg_decode(nibble) : 7'b1111111;
`ifdef SSD_DP_EN
    dp_nxt     = ~(lit & active_dp[idx]);
`else
    dp_nxt     = 1'b1;
`endif
  end

  always_ff @(posedge board_clk) begin
    if (!reset_n) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= 2'd0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      active       <= 16'h0000;
      shadow       <= 16'h0000;
      load_pending <= 1'b0;
      frame_done   <= 1'b0;
      An           <= 4'b1111;
      Cathodes     <= 7'b1111111;
      Dp           <= 1'b1;
`ifdef SSD_DP_EN
      active_dp    <= 4'b0000;
      shadow_dp    <= 4'b0000;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      An         <= an_nxt;
      Cathodes   <= cath_nxt;
      Dp         <= dp_nxt;
      frame_done <= frame_wrap;
      if (slot_wrap)
        idx <= idx + 2'd1;

      if (load) begin
        shadow <= digits_in;
`ifdef SSD_DP_EN
        shadow_dp <= dp_in;
`endif
      end

      // A load landing on the boundary edge bypasses the shadow so it is never left pending.
      if (frame_wrap) begin
        load_pending <= 1'b0;
        if (load) begin
          active <= digits_in;
`ifdef SSD_DP_EN
          active_dp <= dp_in;
`endif
        end else if (load_pending) begin
          active <= shadow;
`ifdef SSD_DP_EN
          active_dp <= shadow_dp;
`endif
        end
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else if (load) begin
        load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
module tb_ssd_scan_ctrl;

  logic        board_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load      = 1'b0;
  logic [3:0]  dp_in     = 4'b0000;
  logic [3:0]  dig_en    = 4'b1111;
  logic [3:0]  blink_en  = 4'b0000;
  logic        load_pending, frame_done, Dp;
  logic [3:0]  An;
  logic [6:0]  Cathodes;

  int checks = 0;
  int fails  = 0;

`ifdef SSD_DP_EN
  localparam logic [3:0] DPM = 4'b0001;
`else
  localparam logic [3:0] DPM = 4'b0000;
`endif

  // {c3,c2,c1,c0} segment images per frame
  localparam logic [27:0] CX_4321 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
  localparam logic [27:0] CX_ABCD = {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
  localparam logic [27:0] CX_8765 = {7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
  localparam logic [27:0] CX_0000 = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

  ssd_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
    .board_clk    (board_clk),
    .reset_n      (reset_n),
    .digits_in    (digits_in),
    .load         (load),
`ifdef SSD_DP_EN
    .dp_in        (dp_in),
`endif
    .dig_en       (dig_en),
    .blink_en     (blink_en),
    .load_pending (load_pending),
    .frame_done   (frame_done),
    .An           (An),
    .Cathodes     (Cathodes),
    .Dp           (Dp)
  );

  always #5 board_clk = ~board_clk;

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Called just after a boundary edge; steps through one full frame and ends on the next boundary edge.
  task automatic run_frame(input logic [27:0] cx, input logic [3:0] lit, input logic [3:0] dpm,
                           input int la1, input logic [15:0] d1, input int la2, input logic [15:0] d2);
    for (int i = 1; i <= 32; i++) begin
      int m, slot, c;
      logic on;
      step();
      m    = i - 1;
      slot = m / 8;
      c    = m % 8;
      on   = (c >= 2) && lit[slot];
      chk("an", {12'h0, An}, on ? {12'h0, ~(4'b0001 << slot)} : 16'h000F);
      chk("cathodes", {9'h0, Cathodes}, on ? {9'h0, cx[slot*7 +: 7]} : 16'h007F);
      chk("dp", {15'h0, Dp}, {15'h0, ~(on & dpm[slot])});
      chk("frame_done", {15'h0, frame_done}, {15'h0, (i == 32)});
      chk("load_pending", {15'h0, load_pending},
          {15'h0, (((la1 >= 1) && (la1 + 1 <= i)) || ((la2 >= 1) && (la2 + 1 <= i))) && (i < 32)});
      load = (i == la1) || (i == la2);
      if (i == la1) digits_in = d1;
      else if (i == la2) digits_in = d2;
    end
    load = 1'b0;
  endtask

  initial begin
    // reset and first-lit latency
    step_n(3);
    chk("rst_an", {12'h0, An}, 16'h000F);
    chk("rst_cath", {9'h0, Cathodes}, 16'h007F);
    chk("rst_dp", {15'h0, Dp}, 16'h0001);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    chk("rst_pending", {15'h0, load_pending}, 16'h0000);
    reset_n = 1'b1;
    step();
    chk("rel1_an", {12'h0, An}, 16'h000F);
    step();
    chk("rel2_an", {12'h0, An}, 16'h000F);
    step();
    chk("rel3_an", {12'h0, An}, 16'h000E);
    chk("rel3_cath", {9'h0, Cathodes}, 16'h0001);

    // load mid-frame is deferred to the boundary
    load = 1'b1;
    digits_in = 16'h4321;
    step();
    load = 1'b0;
    chk("pend_set", {15'h0, load_pending}, 16'h0001);
    step_n(8);
    chk("pre_bnd_an", {12'h0, An}, 16'h000D);
    chk("pre_bnd_cath", {9'h0, Cathodes}, 16'h0001);
    step_n(20);
    chk("bnd_frame_done", {15'h0, frame_done}, 16'h0001);
    chk("bnd_pending", {15'h0, load_pending}, 16'h0000);
    chk("bnd_an", {12'h0, An}, 16'h0007);
    chk("bnd_cath", {9'h0, Cathodes}, 16'h0001);

    // 4321 shown; FFFF then ABCD loaded mid-frame
    run_frame(CX_4321, 4'b1111, 4'b0000, 10, 16'hFFFF, 20, 16'hABCD);
    // last load wins; 8765 loaded on the boundary edge
    run_frame(CX_ABCD, 4'b1111, 4'b0000, 31, 16'h8765, -1, 16'h0000);
    run_frame(CX_8765, 4'b1111, 4'b0000, -1, 16'h0000, -1, 16'h0000);

    // blink and enable masks
    dig_en   = 4'b1011;
    blink_en = 4'b0010;
    run_frame(CX_8765, 4'b1011, 4'b0000, -1, 16'h0000, -1, 16'h0000);
    run_frame(CX_8765, 4'b1011, 4'b0000, -1, 16'h0000, -1, 16'h0000);
    run_frame(CX_8765, 4'b1001, 4'b0000, -1, 16'h0000, -1, 16'h0000);
    run_frame(CX_8765, 4'b1001, 4'b0000, -1, 16'h0000, -1, 16'h0000);

    // reset during SHOW of digit 2 with a load pending
    dig_en   = 4'b1111;
    blink_en = 4'b0000;
    load = 1'b1;
    digits_in = 16'h1234;
    step();
    load = 1'b0;
    chk("mid_pend", {15'h0, load_pending}, 16'h0001);
    step_n(19);
    chk("mid_an", {12'h0, An}, 16'h000B);
    chk("mid_cath", {9'h0, Cathodes}, 16'h000F);
    reset_n = 1'b0;
    step();
    chk("abort_an", {12'h0, An}, 16'h000F);
    chk("abort_cath", {9'h0, Cathodes}, 16'h007F);
    chk("abort_dp", {15'h0, Dp}, 16'h0001);
    chk("abort_frame_done", {15'h0, frame_done}, 16'h0000);
    chk("abort_pending", {15'h0, load_pending}, 16'h0000);
    reset_n = 1'b1;
    step_n(3);
    chk("restart_an", {12'h0, An}, 16'h000E);
    chk("restart_cath", {9'h0, Cathodes}, 16'h0001);
    step_n(29);
    chk("restart_bnd", {15'h0, frame_done}, 16'h0001);

    // discarded load stays invisible; then zeros with decimal point on digit 0
    dp_in = 4'b0001;
    run_frame(CX_0000, 4'b1111, 4'b0000, 31, 16'h0000, -1, 16'h0000);
    run_frame(CX_0000, 4'b1111, DPM, -1, 16'h0000, -1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
